// File: rtl/buf_id_mgr.sv
// Free-buffer-ID manager for the packet data cache.
// Holds a circular free list of NUM_BUF IDs, grants one ID per packet to the
// write path, commits or discards it, and frees multicast buffers only after
// their last reader releases them (per-ID reference counts).
module buf_id_mgr #(
  parameter int NUM_BUF = 16,
  parameter int ID_W    = 4,
  parameter int OFF_W   = 7,
  parameter int RC_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  output logic [ID_W:0]         free_cnt,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [ID_W-1:0]       alloc_id,
  output logic [ID_W+OFF_W-1:0] alloc_waddr,
  input  logic                  wr_done,
  input  logic                  wr_keep,
  input  logic [RC_W-1:0]       wr_refcnt,
  output logic                  commit_valid,
  output logic [ID_W-1:0]       commit_id,
  input  logic                  rd_req,
  input  logic [ID_W-1:0]       rd_id,
  output logic                  rd_raddr_wr,
  output logic [ID_W+OFF_W-1:0] rd_raddr,
  input  logic                  rd_done,
  input  logic [ID_W-1:0]       rd_done_id,
  output logic                  err_free
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         fl_mem_q [NUM_BUF];
  logic [ID_W-1:0]         fl_mem_d [NUM_BUF];
  logic [RC_W-1:0]         refcnt_q [NUM_BUF];
  logic [RC_W-1:0]         refcnt_d [NUM_BUF];
  logic [ID_W-1:0]         head_q, head_d;
  logic [ID_W-1:0]         tail_q, tail_d;
  logic [ID_W:0]           cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    alloc_gnt_q, alloc_gnt_d;
  logic [ID_W-1:0]         alloc_id_q, alloc_id_d;
  logic                    commit_valid_q, commit_valid_d;
  logic [ID_W-1:0]         commit_id_q, commit_id_d;
  logic                    rd_raddr_wr_q, rd_raddr_wr_d;
  logic [ID_W+OFF_W-1:0]   rd_raddr_q, rd_raddr_d;
  logic                    err_free_q, err_free_d;

  logic                    do_pop;
  logic                    disc_push;
  logic                    rel_push;
  logic [ID_W-1:0]         tail_inc;
  logic [ID_W-1:0]         rel_slot;

  // Pointer increment that wraps at NUM_BUF (which need not be a power of two).
  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state: FSM, free-list push/pop, refcounts and all registered outputs.
  always_comb begin
    state_d        = state_q;
    fl_mem_d       = fl_mem_q;
    refcnt_d       = refcnt_q;
    head_d         = head_q;
    tail_d         = tail_q;
    cnt_d          = cnt_q;
    init_done_d    = init_done_q;
    alloc_gnt_d    = 1'b0;
    alloc_id_d     = alloc_id_q;
    commit_valid_d = 1'b0;
    commit_id_d    = commit_id_q;
    rd_raddr_wr_d  = 1'b0;
    rd_raddr_d     = rd_raddr_q;
    err_free_d     = 1'b0;
    do_pop         = 1'b0;
    disc_push      = 1'b0;
    rel_push       = 1'b0;
    tail_inc       = ptr_inc(tail_q);
    rel_slot       = tail_q;

    // Reader release: evaluated before the commit so a commit write wins.
    if (rd_done) begin
      if (state_q == S_INIT) begin
        err_free_d = 1'b1;
      end else if (refcnt_q[rd_done_id] > RC_W'(1)) begin
        refcnt_d[rd_done_id] = refcnt_q[rd_done_id] - 1'b1;
      end else if (refcnt_q[rd_done_id] == RC_W'(1)) begin
        refcnt_d[rd_done_id] = '0;
        rel_push             = 1'b1;
      end else begin
        err_free_d = 1'b1;
      end
    end

    case (state_q)
      S_INIT: begin
        // tail doubles as the loader index: ID k lands in slot k in cycle k
        fl_mem_d[tail_q] = tail_q;
        tail_d           = tail_inc;
        cnt_d            = cnt_q + 1'b1;
        if (tail_q == ID_W'(NUM_BUF - 1)) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (alloc_req && (cnt_q != '0)) begin
          do_pop      = 1'b1;
          alloc_gnt_d = 1'b1;
          alloc_id_d  = fl_mem_q[head_q];
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (wr_done) begin
          state_d = S_IDLE;
          if (wr_keep && (wr_refcnt != '0)) begin
            refcnt_d[alloc_id_q] = wr_refcnt;
            commit_valid_d       = 1'b1;
            commit_id_d          = alloc_id_q;
          end else begin
            disc_push = 1'b1;
          end
        end
      end
      default: state_d = S_INIT;
    endcase

    // Discarded ID goes first at tail, a released ID follows it.
    if (state_q != S_INIT) begin
      if (disc_push) begin
        fl_mem_d[tail_q] = alloc_id_q;
        rel_slot         = tail_inc;
      end
      if (rel_push) begin
        fl_mem_d[rel_slot] = rd_done_id;
      end
      case ({disc_push, rel_push})
        2'b11:        tail_d = ptr_inc(tail_inc);
        2'b10, 2'b01: tail_d = tail_inc;
        default:      tail_d = tail_q;
      endcase
      if (do_pop) begin
        head_d = ptr_inc(head_q);
      end
      cnt_d = cnt_q + (ID_W+1)'(disc_push) + (ID_W+1)'(rel_push) - (ID_W+1)'(do_pop);
    end

    if (init_done_q && rd_req) begin
      rd_raddr_wr_d = 1'b1;
      rd_raddr_d    = {rd_id, {OFF_W{1'b0}}};
    end
  end

  // State and output registers; asynchronous reset forfeits all outstanding IDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      for (int i = 0; i < NUM_BUF; i++) begin
        fl_mem_q[i] <= '0;
        refcnt_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      cnt_q          <= '0;
      init_done_q    <= 1'b0;
      alloc_gnt_q    <= 1'b0;
      alloc_id_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      rd_raddr_wr_q  <= 1'b0;
      rd_raddr_q     <= '0;
      err_free_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      fl_mem_q       <= fl_mem_d;
      refcnt_q       <= refcnt_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      cnt_q          <= cnt_d;
      init_done_q    <= init_done_d;
      alloc_gnt_q    <= alloc_gnt_d;
      alloc_id_q     <= alloc_id_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      rd_raddr_wr_q  <= rd_raddr_wr_d;
      rd_raddr_q     <= rd_raddr_d;
      err_free_q     <= err_free_d;
    end
  end

  assign init_done    = init_done_q;
  assign free_cnt     = cnt_q;
  assign alloc_gnt    = alloc_gnt_q;
  assign alloc_id     = alloc_id_q;
  assign alloc_waddr  = {alloc_id_q, {OFF_W{1'b0}}};
  assign commit_valid = commit_valid_q;
  assign commit_id    = commit_id_q;
  assign rd_raddr_wr  = rd_raddr_wr_q;
  assign rd_raddr     = rd_raddr_q;
  assign err_free     = err_free_q;

endmodule

// File: tb/tb_buf_id_mgr.sv
// Directed bench for buf_id_mgr: init load, grant order, exhaustion,
// multicast release, discard, simultaneous push/pop and read addressing.
module tb_buf_id_mgr;
  localparam int NUM_BUF = 16;
  localparam int ID_W    = 4;
  localparam int OFF_W   = 7;
  localparam int RC_W    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  init_done;
  logic [ID_W:0]         free_cnt;
  logic                  alloc_req;
  logic                  alloc_gnt;
  logic [ID_W-1:0]       alloc_id;
  logic [ID_W+OFF_W-1:0] alloc_waddr;
  logic                  wr_done;
  logic                  wr_keep;
  logic [RC_W-1:0]       wr_refcnt;
  logic                  commit_valid;
  logic [ID_W-1:0]       commit_id;
  logic                  rd_req;
  logic [ID_W-1:0]       rd_id;
  logic                  rd_raddr_wr;
  logic [ID_W+OFF_W-1:0] rd_raddr;
  logic                  rd_done;
  logic [ID_W-1:0]       rd_done_id;
  logic                  err_free;

  int n_pass  = 0;
  int n_total = 0;

  buf_id_mgr #(.NUM_BUF(NUM_BUF), .ID_W(ID_W), .OFF_W(OFF_W), .RC_W(RC_W)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .free_cnt(free_cnt),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
    .alloc_waddr(alloc_waddr), .wr_done(wr_done), .wr_keep(wr_keep),
    .wr_refcnt(wr_refcnt), .commit_valid(commit_valid), .commit_id(commit_id),
    .rd_req(rd_req), .rd_id(rd_id), .rd_raddr_wr(rd_raddr_wr), .rd_raddr(rd_raddr),
    .rd_done(rd_done), .rd_done_id(rd_done_id), .err_free(err_free)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold alloc_req until a grant (bounded); returns the granted ID.
  task automatic do_alloc(output logic [ID_W-1:0] id);
    int w;
    w = 0;
    alloc_req = 1'b1;
    do begin
      tick();
      w++;
    end while (!alloc_gnt && w < 20);
    alloc_req = 1'b0;
    n_total++;
    if (alloc_gnt !== 1'b1) $display("FAIL alloc_gnt_timeout got=%0b want=1", alloc_gnt);
    else n_pass++;
    id = alloc_id;
  endtask

  task automatic do_wr(input logic keep, input logic [RC_W-1:0] rc);
    wr_done = 1'b1; wr_keep = keep; wr_refcnt = rc;
    tick();
    wr_done = 1'b0; wr_keep = 1'b0; wr_refcnt = '0;
  endtask

  task automatic do_rel(input logic [ID_W-1:0] id);
    rd_done = 1'b1; rd_done_id = id;
    tick();
    rd_done = 1'b0; rd_done_id = '0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 1;
    while (!init_done && n < 40) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 16) $display("FAIL %s_init_cycles got=%0d want=16", tag, n);
    else n_pass++;
    n_total++;
    if (free_cnt !== 5'd16) $display("FAIL %s_init_free_cnt got=%0d want=16", tag, free_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alloc_req = 0; wr_done = 0; wr_keep = 0; wr_refcnt = '0;
    rd_req = 0; rd_id = '0; rd_done = 0; rd_done_id = '0;
    repeat (2) tick();
    n_total++;
    if ({init_done, alloc_gnt, commit_valid, rd_raddr_wr, err_free} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000",
               {init_done, alloc_gnt, commit_valid, rd_raddr_wr, err_free});
    else n_pass++;
    n_total++;
    if (free_cnt !== 5'd0) $display("FAIL reset_free_cnt got=%0d want=0", free_cnt);
    else n_pass++;
    // release reset; a rd_done during INIT is ignored but flagged
    rst_n = 1'b1;
    rd_done = 1'b1; rd_done_id = 4'd0;
    tick();
    rd_done = 1'b0;
    n_total++;
    if (err_free !== 1'b1) $display("FAIL init_rd_done_err got=%0b want=1", err_free);
    else n_pass++;
    wait_init("reset");
  endtask

  task automatic test_fill();
    logic [ID_W-1:0] id;
    logic got;
    for (int i = 0; i < 16; i++) begin
      do_alloc(id);
      n_total++;
      if (id !== ID_W'(i) || alloc_waddr !== {ID_W'(i), 7'b0})
        $display("FAIL fill_grant_%0d got id=%0d waddr=%h want id=%0d", i, id, alloc_waddr, i);
      else n_pass++;
      do_wr(1'b1, 3'd1);
      n_total++;
      if (commit_valid !== 1'b1 || commit_id !== ID_W'(i))
        $display("FAIL fill_commit_%0d got v=%0b id=%0d want v=1 id=%0d", i, commit_valid, commit_id, i);
      else n_pass++;
    end
    n_total++;
    if (free_cnt !== 5'd0) $display("FAIL fill_empty got=%0d want=0", free_cnt);
    else n_pass++;
    alloc_req = 1'b1;
    got = 1'b0;
    repeat (4) begin
      tick();
      if (alloc_gnt) got = 1'b1;
    end
    n_total++;
    if (got !== 1'b0) $display("FAIL empty_no_grant got=%0b want=0", got);
    else n_pass++;
    do_rel(4'd9);
    n_total++;
    if (alloc_gnt !== 1'b0 || free_cnt !== 5'd1)
      $display("FAIL empty_return got gnt=%0b cnt=%0d want gnt=0 cnt=1", alloc_gnt, free_cnt);
    else n_pass++;
    tick();
    alloc_req = 1'b0;
    n_total++;
    if (alloc_gnt !== 1'b1 || alloc_id !== 4'd9 || free_cnt !== 5'd0)
      $display("FAIL empty_regrant got gnt=%0b id=%0d cnt=%0d want 1/9/0", alloc_gnt, alloc_id, free_cnt);
    else n_pass++;
    do_wr(1'b1, 3'd1);
    for (int i = 0; i < 16; i++) do_rel(ID_W'(i));
    n_total++;
    if (free_cnt !== 5'd16) $display("FAIL fill_all_released got=%0d want=16", free_cnt);
    else n_pass++;
  endtask

  task automatic test_multicast();
    logic [ID_W-1:0] id;
    for (int i = 0; i < 5; i++) begin
      do_alloc(id);
      n_total++;
      if (id !== ID_W'(i)) $display("FAIL mc_rotate_%0d got=%0d want=%0d", i, id, i);
      else n_pass++;
      do_wr(1'b0, 3'd1);
      n_total++;
      if (commit_valid !== 1'b0) $display("FAIL mc_rotate_nocommit_%0d got=%0b want=0", i, commit_valid);
      else n_pass++;
    end
    do_alloc(id);
    n_total++;
    if (id !== 4'd5) $display("FAIL mc_grant got=%0d want=5", id);
    else n_pass++;
    do_wr(1'b1, 3'd3);
    n_total++;
    if (commit_valid !== 1'b1 || commit_id !== 4'd5 || free_cnt !== 5'd15)
      $display("FAIL mc_commit got v=%0b id=%0d cnt=%0d want 1/5/15", commit_valid, commit_id, free_cnt);
    else n_pass++;
    do_rel(4'd5);
    do_rel(4'd5);
    n_total++;
    if (free_cnt !== 5'd15) $display("FAIL mc_two_reads got=%0d want=15", free_cnt);
    else n_pass++;
    do_rel(4'd5);
    n_total++;
    if (free_cnt !== 5'd16) $display("FAIL mc_last_read got=%0d want=16", free_cnt);
    else n_pass++;
  endtask

  task automatic test_discard();
    logic [ID_W-1:0] id;
    // rotate 6..15,0,1 through; alternate keep=0 and keep=1 with refcnt 0
    for (int i = 0; i < 12; i++) begin
      do_alloc(id);
      n_total++;
      if (id !== ID_W'((6 + i) % 16)) $display("FAIL disc_rotate_%0d got=%0d want=%0d", i, id, (6 + i) % 16);
      else n_pass++;
      if (i % 2 == 0) do_wr(1'b0, 3'd1);
      else            do_wr(1'b1, 3'd0);
      n_total++;
      if (commit_valid !== 1'b0) $display("FAIL disc_nocommit_%0d got=%0b want=0", i, commit_valid);
      else n_pass++;
    end
    do_alloc(id);
    n_total++;
    if (id !== 4'd2 || free_cnt !== 5'd15)
      $display("FAIL disc_grant got id=%0d cnt=%0d want 2/15", id, free_cnt);
    else n_pass++;
    do_wr(1'b0, 3'd2);
    n_total++;
    if (commit_valid !== 1'b0 || free_cnt !== 5'd16)
      $display("FAIL disc_return got v=%0b cnt=%0d want 0/16", commit_valid, free_cnt);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [ID_W-1:0] id;
    do_alloc(id);
    do_wr(1'b1, 3'd1);
    n_total++;
    if (id !== 4'd3 || commit_id !== 4'd3) $display("FAIL sim_grant3 got id=%0d cid=%0d want 3", id, commit_id);
    else n_pass++;
    do_alloc(id);
    do_wr(1'b1, 3'd1);
    n_total++;
    if (id !== 4'd4 || free_cnt !== 5'd14) $display("FAIL sim_grant4 got id=%0d cnt=%0d want 4/14", id, free_cnt);
    else n_pass++;
    // pop and release push in the same cycle
    alloc_req = 1'b1; rd_done = 1'b1; rd_done_id = 4'd3;
    tick();
    alloc_req = 1'b0; rd_done = 1'b0;
    n_total++;
    if (alloc_gnt !== 1'b1 || alloc_id !== 4'd5 || free_cnt !== 5'd14)
      $display("FAIL sim_pop_push got gnt=%0b id=%0d cnt=%0d want 1/5/14", alloc_gnt, alloc_id, free_cnt);
    else n_pass++;
    // discard push and release push in the same cycle
    wr_done = 1'b1; wr_keep = 1'b0; wr_refcnt = 3'd0;
    rd_done = 1'b1; rd_done_id = 4'd4;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
    n_total++;
    if (commit_valid !== 1'b0 || free_cnt !== 5'd16)
      $display("FAIL sim_double_push got v=%0b cnt=%0d want 0/16", commit_valid, free_cnt);
    else n_pass++;
    for (int i = 0; i < 14; i++) begin
      do_alloc(id);
      n_total++;
      if (id !== ID_W'((6 + i) % 16)) $display("FAIL sim_rotate_%0d got=%0d want=%0d", i, id, (6 + i) % 16);
      else n_pass++;
      do_wr(1'b0, 3'd0);
    end
    do_alloc(id);
    n_total++;
    if (id !== 4'd5) $display("FAIL sim_order_first got=%0d want=5", id);
    else n_pass++;
    do_wr(1'b0, 3'd0);
    do_alloc(id);
    n_total++;
    if (id !== 4'd4) $display("FAIL sim_order_second got=%0d want=4", id);
    else n_pass++;
    do_wr(1'b0, 3'd0);
  endtask

  task automatic test_err_and_read();
    do_rel(4'd7);
    n_total++;
    if (err_free !== 1'b1 || free_cnt !== 5'd16)
      $display("FAIL err_free_pulse got e=%0b cnt=%0d want 1/16", err_free, free_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (err_free !== 1'b0) $display("FAIL err_free_single got=%0b want=0", err_free);
    else n_pass++;
    rd_req = 1'b1; rd_id = 4'd3;
    tick();
    rd_req = 1'b0;
    n_total++;
    if (rd_raddr_wr !== 1'b1 || rd_raddr !== 11'h180)
      $display("FAIL rd_addr got wr=%0b addr=%h want 1/180", rd_raddr_wr, rd_raddr);
    else n_pass++;
    tick();
    n_total++;
    if (rd_raddr_wr !== 1'b0) $display("FAIL rd_addr_pulse got=%0b want=0", rd_raddr_wr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [ID_W-1:0] id;
    do_alloc(id);
    n_total++;
    if (id !== 4'd6) $display("FAIL mid_pre_grant got=%0d want=6", id);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (init_done !== 1'b0 || free_cnt !== 5'd0 || alloc_id !== 4'd0)
      $display("FAIL mid_async_clear got done=%0b cnt=%0d id=%0d want 0/0/0", init_done, free_cnt, alloc_id);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    wait_init("mid");
    do_alloc(id);
    n_total++;
    if (id !== 4'd0) $display("FAIL mid_regrant got=%0d want=0", id);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_multicast();
    test_discard();
    test_simultaneous();
    test_err_and_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
